// File: rtl/i2c_reg_pkg.sv
// Shared definitions for the I2C register bank: address-FSM state codes and
// byte-address decode helpers (all helpers assume bases aligned to reg_bytes).
package i2c_reg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    function automatic logic is_rw(input logic [7:0] addr, input int reg_bytes, input int num_rw);
        return int'(addr) < reg_bytes * num_rw;
    endfunction

    function automatic logic is_ro(input logic [7:0] addr, input int ro_base, input int reg_bytes,
                                   input int num_ro);
        return (int'(addr) >= ro_base) && (int'(addr) < ro_base + reg_bytes * num_ro);
    endfunction

    function automatic logic [7:0] reg_index(input logic [7:0] addr, input int base, input int reg_bytes);
        return 8'((int'(addr) - base) / reg_bytes);
    endfunction

    function automatic logic [7:0] byte_index(input logic [7:0] addr, input int reg_bytes);
        return 8'(int'(addr) % reg_bytes);
    endfunction

endpackage

// File: rtl/i2c_reg_pulse.sv
// Self-clearing pulse register: a load holds the written bits for PULSE_HOLD
// clocks; a reload restarts the hold window.
module i2c_reg_pulse #(
    parameter int PULSE_HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] pulse_out
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (load) begin
            cnt_d   = 8'(PULSE_HOLD);
            pulse_d = load_val;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) pulse_d = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            pulse_q <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave engine: staged atomic RW commits,
// snapshot-coherent RO reads and a self-clearing pulse register.
//   state    | meaning
//   ST_IDLE  | bus idle, strobes ignored
//   ST_ADDR  | after (repeated) start, waiting for pointer byte or read
//   ST_WRITE | each byte written at ptr, ptr advances
//   ST_READ  | each byte taken advances ptr
module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int                          REG_BYTES  = 4,
    parameter int                          NUM_RW     = 8,
    parameter int                          NUM_RO     = 4,
    parameter logic [7:0]                  RO_BASE    = 8'h40,
    parameter logic [7:0]                  PULSE_ADDR = 8'h7F,
    parameter int                          PULSE_HOLD = 3,
    parameter logic [NUM_RW*REG_BYTES*8-1:0] RW_RESET = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            data_vld,
    input  logic                            r_w,
    input  logic [7:0]                      i2c_to_data,
    output logic [7:0]                      data_to_i2c,
    output logic [NUM_RW*REG_BYTES*8-1:0]   rw_regs,
    output logic [NUM_RW-1:0]               rw_strobe,
    input  logic [NUM_RO*REG_BYTES*8-1:0]   ro_regs,
    output logic [7:0]                      pulse_out,
    output logic [7:0]                      ptr
);

    localparam int REG_W = REG_BYTES * 8;

    logic [1:0]              state_q, state_d;
    logic [7:0]              ptr_q, ptr_d;
    logic [REG_W-1:0]        stg_data_q, stg_data_d;
    logic [REG_BYTES-1:0]    stg_mask_q, stg_mask_d;
    logic [7:0]              stg_idx_q, stg_idx_d;
    logic [NUM_RW*REG_W-1:0] rw_regs_q, rw_regs_d;
    logic [NUM_RW-1:0]       rw_strobe_q, rw_strobe_d;
    logic [REG_W-1:0]        snap_q, snap_d;
    logic [7:0]              snap_idx_q, snap_idx_d;
    logic                    snap_vld_q, snap_vld_d;
    logic [7:0]              rd_q, rd_d;

    logic                    byte_in, wr_en, wr_rw, pulse_load;
    logic                    ptr_is_rw, ptr_is_ro;
    logic [7:0]              ptr_rw_idx, ptr_ro_idx, ptr_byte;
    logic                    commit_a, commit_b;
    logic [REG_W-1:0]        m_data;
    logic [REG_BYTES-1:0]    m_mask;
    logic [7:0]              m_idx;

    assign ptr_is_rw  = is_rw(ptr_q, REG_BYTES, NUM_RW);
    assign ptr_is_ro  = is_ro(ptr_q, int'(RO_BASE), REG_BYTES, NUM_RO);
    assign ptr_rw_idx = reg_index(ptr_q, 0, REG_BYTES);
    assign ptr_ro_idx = reg_index(ptr_q, int'(RO_BASE), REG_BYTES);
    assign ptr_byte   = byte_index(ptr_q, REG_BYTES);

    // A start in the same cycle as data_vld drops the byte.
    assign byte_in    = data_vld & ~start;
    assign wr_en      = byte_in & (state_q == ST_WRITE);
    assign wr_rw      = wr_en & ptr_is_rw;
    assign pulse_load = wr_en & ~ptr_is_rw & ~ptr_is_ro & (ptr_q == PULSE_ADDR);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (byte_in) begin
            case (state_q)
                ST_ADDR:           ptr_d = r_w ? ptr_q + 8'd1 : i2c_to_data;
                ST_WRITE, ST_READ: ptr_d = ptr_q + 8'd1;
                default:           ptr_d = ptr_q;
            endcase
        end
        if (start) begin
            state_d = ST_ADDR;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_ADDR) begin
            if (r_w)           state_d = ST_READ;
            else if (data_vld) state_d = ST_WRITE;
        end
    end

    // commit_a flushes the previous register when a write moves to another
    // index; commit_b flushes the (possibly just extended) staging buffer.
    always_comb begin
        commit_a = 1'b0;
        m_data   = stg_data_q;
        m_mask   = stg_mask_q;
        m_idx    = stg_idx_q;
        if (wr_rw) begin
            if ((|stg_mask_q) && (ptr_rw_idx != stg_idx_q)) begin
                commit_a = 1'b1;
                m_mask   = '0;
            end
            m_idx = ptr_rw_idx;
            for (int b = 0; b < REG_BYTES; b++) begin
                if (ptr_byte == 8'(b)) begin
                    m_mask[b]        = 1'b1;
                    m_data[b*8 +: 8] = i2c_to_data;
                end
            end
        end
        commit_b   = (|m_mask) && (start || stop || (wr_rw && ptr_byte == 8'(REG_BYTES - 1)));
        stg_data_d = m_data;
        stg_mask_d = commit_b ? '0 : m_mask;
        stg_idx_d  = m_idx;
    end

    always_comb begin
        rw_regs_d   = rw_regs_q;
        rw_strobe_d = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            for (int b = 0; b < REG_BYTES; b++) begin
                if (commit_a && stg_idx_q == 8'(k) && stg_mask_q[b])
                    rw_regs_d[k*REG_W + b*8 +: 8] = stg_data_q[b*8 +: 8];
                if (commit_b && m_idx == 8'(k) && m_mask[b])
                    rw_regs_d[k*REG_W + b*8 +: 8] = m_data[b*8 +: 8];
            end
            rw_strobe_d[k] = (commit_a && stg_idx_q == 8'(k)) || (commit_b && m_idx == 8'(k));
        end
    end

    always_comb begin
        rd_d       = 8'h00;
        snap_d     = snap_q;
        snap_idx_d = snap_idx_q;
        snap_vld_d = snap_vld_q;
        if (ptr_is_rw) begin
            for (int k = 0; k < NUM_RW; k++)
                for (int b = 0; b < REG_BYTES; b++)
                    if (ptr_rw_idx == 8'(k) && ptr_byte == 8'(b))
                        rd_d = rw_regs_q[k*REG_W + b*8 +: 8];
        end else if (ptr_is_ro) begin
            for (int k = 0; k < NUM_RO; k++)
                for (int b = 0; b < REG_BYTES; b++)
                    if (ptr_ro_idx == 8'(k) && ptr_byte == 8'(b))
                        rd_d = (b != 0 && snap_vld_q && snap_idx_q == 8'(k)) ?
                               snap_q[b*8 +: 8] : ro_regs[k*REG_W + b*8 +: 8];
        end else if (ptr_q == PULSE_ADDR) begin
            rd_d = pulse_out;
        end
        if (!r_w) rd_d = 8'h00;

        if (start || stop) begin
            snap_vld_d = 1'b0;
        end else if (r_w && ptr_is_ro && ptr_byte == 8'd0) begin
            for (int k = 0; k < NUM_RO; k++)
                if (ptr_ro_idx == 8'(k)) snap_d = ro_regs[k*REG_W +: REG_W];
            snap_idx_d = ptr_ro_idx;
            snap_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 8'h00;
            stg_data_q  <= '0;
            stg_mask_q  <= '0;
            stg_idx_q   <= 8'h00;
            rw_regs_q   <= RW_RESET;
            rw_strobe_q <= '0;
            snap_q      <= '0;
            snap_idx_q  <= 8'h00;
            snap_vld_q  <= 1'b0;
            rd_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            stg_data_q  <= stg_data_d;
            stg_mask_q  <= stg_mask_d;
            stg_idx_q   <= stg_idx_d;
            rw_regs_q   <= rw_regs_d;
            rw_strobe_q <= rw_strobe_d;
            snap_q      <= snap_d;
            snap_idx_q  <= snap_idx_d;
            snap_vld_q  <= snap_vld_d;
            rd_q        <= rd_d;
        end
    end

    i2c_reg_pulse #(.PULSE_HOLD(PULSE_HOLD)) u_pulse (
        .clk       (clk),
        .rst       (rst),
        .load      (pulse_load),
        .load_val  (i2c_to_data),
        .pulse_out (pulse_out)
    );

    assign data_to_i2c = rd_q;
    assign rw_regs     = rw_regs_q;
    assign rw_strobe   = rw_strobe_q;
    assign ptr         = ptr_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: byte-level model of the register map driven by
// directed and random I2C transactions.
module tb_i2c_reg_bank;

    localparam int RB   = 4;
    localparam int NRW  = 8;
    localparam int NRO  = 4;
    localparam int HOLD = 3;

    logic                 clk = 1'b0, rst = 1'b1;
    logic                 start = 1'b0, stop = 1'b0, data_vld = 1'b0, r_w = 1'b0;
    logic [7:0]           i2c_to_data = 8'h00;
    logic [7:0]           data_to_i2c, pulse_out, ptr;
    logic [NRW*RB*8-1:0]  rw_regs;
    logic [NRW-1:0]       rw_strobe;
    logic [NRO*RB*8-1:0]  ro_regs = '0;

    i2c_reg_bank #(
        .REG_BYTES(RB), .NUM_RW(NRW), .NUM_RO(NRO), .RO_BASE(8'h40),
        .PULSE_ADDR(8'h7F), .PULSE_HOLD(HOLD), .RW_RESET('0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .data_vld(data_vld), .r_w(r_w),
        .i2c_to_data(i2c_to_data), .data_to_i2c(data_to_i2c), .rw_regs(rw_regs),
        .rw_strobe(rw_strobe), .ro_regs(ro_regs), .pulse_out(pulse_out), .ptr(ptr)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    int strobe_seen [NRW];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) for (int k = 0; k < NRW; k++) if (rw_strobe[k]) strobe_seen[k]++;

    // Reference model: committed bytes, pending bytes of one register, pointer.
    logic [7:0] m_rw [NRW*RB];
    int         m_strobe [NRW];
    int         pend_reg = -1;
    logic [7:0] pend_val [RB];
    bit         pend_has [RB];
    int         m_ptr = 0;
    logic [7:0] m_pulse_val = 8'h00;
    int         m_pulse_cyc = -100;

    task automatic m_commit();
        bit any;
        any = 1'b0;
        if (pend_reg >= 0) begin
            for (int b = 0; b < RB; b++) begin
                if (pend_has[b]) begin
                    m_rw[pend_reg*RB + b] = pend_val[b];
                    pend_has[b] = 1'b0;
                    any = 1'b1;
                end
            end
            if (any) m_strobe[pend_reg]++;
        end
        pend_reg = -1;
    endtask

    task automatic m_write(input logic [7:0] d);
        if (m_ptr < NRW*RB) begin
            if (pend_reg != m_ptr / RB) m_commit();
            pend_reg = m_ptr / RB;
            pend_has[m_ptr % RB] = 1'b1;
            pend_val[m_ptr % RB] = d;
            if (m_ptr % RB == RB - 1) m_commit();
        end else if (m_ptr == 'h7F) begin
            m_pulse_val = d;
            m_pulse_cyc = cyc;
        end
        m_ptr = (m_ptr + 1) % 256;
    endtask

    function automatic logic [NRW*RB*8-1:0] m_packed();
        logic [NRW*RB*8-1:0] v;
        for (int i = 0; i < NRW*RB; i++) v[i*8 +: 8] = m_rw[i];
        return v;
    endfunction

    function automatic logic [7:0] m_pulse_exp();
        return (cyc - m_pulse_cyc < HOLD) ? m_pulse_val : 8'h00;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a < NRW*RB) return m_rw[a];
        if (a >= 'h40 && a < 'h40 + NRO*RB) return ro_regs[(a - 'h40)*8 +: 8];
        if (a == 'h7F) return m_pulse_exp();
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        start = 1'b1; tick(); start = 1'b0;
        m_commit();
    endtask

    task automatic bus_stop();
        stop = 1'b1; tick(); stop = 1'b0;
        m_commit();
    endtask

    task automatic bus_addr(input logic [7:0] a);
        data_vld = 1'b1; i2c_to_data = a; tick(); data_vld = 1'b0;
        m_ptr = a;
    endtask

    task automatic bus_wr(input logic [7:0] d);
        data_vld = 1'b1; i2c_to_data = d; tick(); data_vld = 1'b0;
        m_write(d);
    endtask

    task automatic bus_stop_byte(input logic [7:0] d);
        stop = 1'b1; data_vld = 1'b1; i2c_to_data = d; tick(); stop = 1'b0; data_vld = 1'b0;
        m_write(d);
        m_commit();
    endtask

    task automatic bus_rd_ack();
        data_vld = 1'b1; tick(); data_vld = 1'b0;
        m_ptr = (m_ptr + 1) % 256;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NRW*RB; i++) m_rw[i] = 8'h00;
        rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
        n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL reset_rw_regs got %h exp %h", rw_regs, m_packed()); end
        n_vec++; if (pulse_out !== 8'h00) begin n_err++; $display("FAIL reset_pulse got %h exp 00", pulse_out); end
        n_vec++; if (data_to_i2c !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", data_to_i2c); end
        n_vec++; if (rw_strobe !== '0) begin n_err++; $display("FAIL reset_strobe got %b exp 0", rw_strobe); end
        n_vec++; if (ptr !== 8'h00) begin n_err++; $display("FAIL reset_ptr got %h exp 00", ptr); end
    endtask

    task automatic test_write_full();
        logic [7:0] d [4];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus_start(); bus_addr(8'h04);
        for (int i = 0; i < 3; i++) begin
            bus_wr(d[i]);
            n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL full_hidden_%0d got %h exp %h", i, rw_regs, m_packed()); end
        end
        bus_wr(d[3]);
        n_vec++; if (rw_regs[63:32] !== 32'h44332211) begin n_err++; $display("FAIL full_reg1 got %h exp 44332211", rw_regs[63:32]); end
        n_vec++; if (rw_strobe !== 8'b0000_0010) begin n_err++; $display("FAIL full_strobe got %b exp 00000010", rw_strobe); end
        bus_stop(); tick();
        n_vec++; if (strobe_seen[1] !== 1) begin n_err++; $display("FAIL full_strobe_count got %0d exp 1", strobe_seen[1]); end
    endtask

    task automatic test_partial_stop();
        bus_start(); bus_addr(8'h09); bus_wr(8'hAA); bus_wr(8'hBB);
        n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL partial_hidden got %h exp %h", rw_regs, m_packed()); end
        bus_stop();
        n_vec++; if (rw_strobe !== 8'b0000_0100) begin n_err++; $display("FAIL partial_strobe got %b exp 00000100", rw_strobe); end
        n_vec++; if (rw_regs[95:64] !== 32'h00BBAA00) begin n_err++; $display("FAIL partial_reg2 got %h exp 00bbaa00", rw_regs[95:64]); end
        n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL partial_all got %h exp %h", rw_regs, m_packed()); end
        tick();
    endtask

    task automatic test_ro_snapshot();
        logic [31:0] snap;
        ro_regs[31:0] = 32'h12345678;
        r_w = 1'b0; bus_start(); bus_addr(8'h40);
        r_w = 1'b1; bus_start();
        snap = ro_regs[31:0];
        for (int b = 0; b < RB; b++) begin
            n_vec++; if (data_to_i2c !== snap[b*8 +: 8]) begin n_err++; $display("FAIL ro_snap_b%0d got %h exp %h", b, data_to_i2c, snap[b*8 +: 8]); end
            bus_rd_ack();
            if (b == 0) ro_regs[31:0] = 32'h87654321;
            tick();
        end
        bus_stop(); r_w = 1'b0;
        bus_start(); bus_addr(8'h41);
        r_w = 1'b1; bus_start();
        n_vec++; if (data_to_i2c !== ro_regs[15:8]) begin n_err++; $display("FAIL ro_live_mid got %h exp %h", data_to_i2c, ro_regs[15:8]); end
        bus_stop(); r_w = 1'b0; tick();
        n_vec++; if (data_to_i2c !== 8'h00) begin n_err++; $display("FAIL ro_wr_mode_data got %h exp 00", data_to_i2c); end
    endtask

    task automatic test_pulse();
        bus_start(); bus_addr(8'h7F); bus_wr(8'h05);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (pulse_out !== m_pulse_exp()) begin n_err++; $display("FAIL pulse_hold_%0d got %h exp %h", i, pulse_out, m_pulse_exp()); end
            tick();
        end
        bus_stop();
        bus_start(); bus_addr(8'h7F); bus_wr(8'h05);
        n_vec++; if (pulse_out !== m_pulse_exp()) begin n_err++; $display("FAIL pulse_re_load got %h exp %h", pulse_out, m_pulse_exp()); end
        bus_start();
        n_vec++; if (pulse_out !== m_pulse_exp()) begin n_err++; $display("FAIL pulse_re_s got %h exp %h", pulse_out, m_pulse_exp()); end
        bus_addr(8'h7F);
        n_vec++; if (pulse_out !== m_pulse_exp()) begin n_err++; $display("FAIL pulse_re_a got %h exp %h", pulse_out, m_pulse_exp()); end
        bus_wr(8'h0A);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (pulse_out !== m_pulse_exp()) begin n_err++; $display("FAIL pulse_rewrite_%0d got %h exp %h", i, pulse_out, m_pulse_exp()); end
            tick();
        end
        bus_stop();
    endtask

    task automatic test_wrap_collide();
        bus_start(); bus_addr(8'hFF);
        n_vec++; if (ptr !== 8'hFF) begin n_err++; $display("FAIL wrap_ptr_ff got %h exp ff", ptr); end
        bus_wr(8'h5A);
        n_vec++; if (ptr !== 8'(m_ptr)) begin n_err++; $display("FAIL wrap_ptr_00 got %h exp %h", ptr, 8'(m_ptr)); end
        bus_wr(8'h66);
        n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL wrap_staged got %h exp %h", rw_regs, m_packed()); end
        start = 1'b1; data_vld = 1'b1; i2c_to_data = 8'h77; tick(); start = 1'b0; data_vld = 1'b0;
        m_commit();
        n_vec++; if (ptr !== 8'h01) begin n_err++; $display("FAIL collide_ptr got %h exp 01", ptr); end
        n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL collide_regs got %h exp %h", rw_regs, m_packed()); end
        n_vec++; if (rw_strobe !== 8'b0000_0001) begin n_err++; $display("FAIL collide_strobe got %b exp 00000001", rw_strobe); end
        bus_stop(); tick();
    endtask

    task automatic test_random_writes();
        int a, n;
        for (int it = 0; it < 30; it++) begin
            a = $urandom_range(0, 36);
            n = $urandom_range(1, 6);
            bus_start();
            bus_addr(8'(a));
            for (int i = 0; i < n - 1; i++) bus_wr(8'($urandom));
            case ($urandom_range(0, 2))
                0:       bus_stop_byte(8'($urandom));
                1:       begin bus_wr(8'($urandom)); bus_stop(); end
                default: bus_wr(8'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) tick();
            tick();
            n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL rand_regs_%0d got %h exp %h", it, rw_regs, m_packed()); end
            n_vec++; if (ptr !== 8'(m_ptr)) begin n_err++; $display("FAIL rand_ptr_%0d got %h exp %h", it, ptr, 8'(m_ptr)); end
            for (int k = 0; k < NRW; k++) begin
                n_vec++; if (strobe_seen[k] !== m_strobe[k]) begin n_err++; $display("FAIL rand_strobe_%0d_r%0d got %0d exp %0d", it, k, strobe_seen[k], m_strobe[k]); end
            end
        end
        bus_stop(); tick();
    endtask

    task automatic test_readback();
        ro_regs = {$urandom, $urandom, $urandom, $urandom};
        r_w = 1'b0; bus_start(); bus_addr(8'h00);
        r_w = 1'b1; bus_start();
        for (int a = 0; a < 'h48; a++) begin
            n_vec++; if (data_to_i2c !== m_read(a)) begin n_err++; $display("FAIL readback_%02h got %h exp %h", a, data_to_i2c, m_read(a)); end
            bus_rd_ack();
            tick();
        end
        bus_stop(); r_w = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        bus_start(); bus_addr(8'h10); bus_wr(8'hC3);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int i = 0; i < NRW*RB; i++) m_rw[i] = 8'h00;
        for (int b = 0; b < RB; b++) pend_has[b] = 1'b0;
        pend_reg = -1; m_ptr = 0; m_pulse_cyc = -100;
        tick();
        n_vec++; if (rw_regs !== m_packed()) begin n_err++; $display("FAIL rstmid_regs got %h exp %h", rw_regs, m_packed()); end
        n_vec++; if (ptr !== 8'h00) begin n_err++; $display("FAIL rstmid_ptr got %h exp 00", ptr); end
        bus_start(); bus_stop(); tick();
        for (int k = 0; k < NRW; k++) begin
            n_vec++; if (strobe_seen[k] !== m_strobe[k]) begin n_err++; $display("FAIL rstmid_strobe_r%0d got %0d exp %0d", k, strobe_seen[k], m_strobe[k]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_full();
        test_partial_stop();
        test_ro_snapshot();
        test_pulse();
        test_wrap_collide();
        test_random_writes();
        test_readback();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
